deg2decimal: RTL
================

Name: deg2decimal

Overview:
- Inverse of the BCD-to-angle converter: takes a 14-bit binary angle code and produces packed-BCD decimal degrees with a selectable number of fractional digits.
- Code weight: MSB = 180 deg, LSB = 180/8192 deg, so degrees = code × 45 / 2048, range [0, 360).
- Sits on the display/readout side of the angle datapath and uses the same start/finished pulse handshake as the forward converter.

Parameters:
- MAX_FRC, 12, maximum fractional digits supported; i_frccnt above this is clamped.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle start request; sampled only in IDLE.
- i_deg  in  14  unsigned binary angle code; sampled with i_start.
- i_frccnt  in  4  number of fractional BCD digits (0..12); sampled with i_start.
- o_decimal  out  64  packed BCD result, right-aligned: 3 integer digits (hundreds, tens, ones) followed by f fractional digits (first fractional digit most significant); unused upper nibbles are 0.
- o_busy  out  1  high from the edge after i_start is accepted until END is left.
- o_finished  out  1  one-cycle done pulse.

Behaviour:
- Reset (async, i_rst=0): state=IDLE; o_decimal=0; o_busy=0; o_finished=0; all internal registers cleared. Reset mid-conversion aborts it, and no o_finished is produced.
- States: IDLE -> MUL -> INT -> FRC -> END -> IDLE.
- IDLE:
  - On i_start=1, latch i_deg and f = min(i_frccnt, MAX_FRC), then go to MUL.
  - i_start while not in IDLE is ignored (no queueing).
- MUL (1 cycle): P = code×45 computed as (c<<5)+(c<<3)+(c<<2)+c, 20 bits (max 737235).
  - Integer part I = P[19:11] (0..359).
  - Fraction F = P[10:0].
- INT (exactly 9 cycles): double-dabble of I into 3 BCD digits, MSB first.
  - Each cycle: add 3 to every digit ≥5, then shift left by 1, taking in the next bit of I.
  - On exit: acc = {52'b0, H, T, O}.
  - If f=0, go to END; otherwise go to FRC.
- FRC (exactly f cycles): per cycle, compute F×10 (15 bits).
  - digit = (F×10)[14:11].
  - F <= (F×10)[10:0].
  - acc <= (acc<<4) | digit.
  - Fractions are truncated, not rounded. Results are exact when f ≥ 11; digit 12 is always 0.
- END (1 cycle): o_decimal <= acc on entry; o_finished=1 during END only; then return to IDLE.
- o_decimal holds its value until the next END; it never shows intermediate values.
- Latency: counting the edge that samples i_start as edge 0, o_finished is high in the cycle following edge 10+f. Maximum latency 22 cycles.
- i_start in the END cycle is ignored. A new start is accepted from IDLE on the following cycle, giving back-to-back throughput of one conversion per 12+f cycles.
- All arithmetic is unsigned; widths are fixed as above, and no overflow is possible.

Test Plan:
- i_deg=0, i_frccnt=4 -> o_decimal=0x0000000 (000.0000); o_finished pulse exactly 14 cycles after start.
- i_deg=8192, i_frccnt=4 -> 0x1800000 (180.0000); i_deg=4096, f=2 -> 0x09000 (090.00); i_deg=2048, f=0 -> 0x045 with latency 10.
- i_deg=1, i_frccnt=4 -> 0x0000219 (truncated 0.02197…); i_deg=1, f=11 -> 0x00002197265625.
- i_deg=16383, i_frccnt=11 -> 0x35997802734375 (359.97802734375); i_frccnt=15 -> clamped to 12 -> 0x359978027343750.
- Pulse i_start and change i_deg while busy -> ignored, result unchanged; back-to-back starts issued the cycle after END both complete correctly; o_busy and o_finished timing checked.
- Assert i_rst low mid-FRC -> all outputs 0 immediately; no o_finished afterwards; the next start converts correctly.

Source files
------------

// File: rtl/deg2decimal_if.sv
// ---------------------------------------------------------------------------
// deg2decimal_if
//   Start/finished pulse handshake and data bus of the binary-angle to
//   packed-BCD degrees converter.
//
//   i_start     1   one-cycle start request (master -> slave)
//   i_deg       14  unsigned binary angle code, MSB = 180 deg
//   i_frccnt    4   requested number of fractional BCD digits
//   o_decimal   64  packed BCD result, right-aligned
//   o_busy      1   conversion in progress
//   o_finished  1   one-cycle done pulse
//
//   master : the requester that drives the start request
//   slave  : the converter
// ---------------------------------------------------------------------------
interface deg2decimal_if;
  logic        i_start;
  logic [13:0] i_deg;
  logic [3:0]  i_frccnt;
  logic [63:0] o_decimal;
  logic        o_busy;
  logic        o_finished;

  modport master (
    output i_start, i_deg, i_frccnt,
    input  o_decimal, o_busy, o_finished
  );

  modport slave (
    input  i_start, i_deg, i_frccnt,
    output o_decimal, o_busy, o_finished
  );
endinterface

// File: rtl/deg2decimal.sv
// ---------------------------------------------------------------------------
// deg2decimal
//   Converts a 14-bit binary angle code (LSB = 180/8192 deg) into packed-BCD
//   decimal degrees: three integer digits followed by f fractional digits,
//   right-aligned, fractions truncated.
//
//   degrees = code * 45 / 2048
//
//   Sequence: IDLE -> MUL (1) -> INT (9) -> FRC (f) -> END (1) -> IDLE
//
//   Ports
//     i_clk  rising-edge clock
//     i_rst  asynchronous active-low reset
//     bus    deg2decimal_if.slave : i_start, i_deg, i_frccnt in;
//                                   o_decimal, o_busy, o_finished out
//
//   Parameter
//     MAX_FRC  largest fractional digit count; larger requests are clamped
// ---------------------------------------------------------------------------
module deg2decimal #(
  parameter int MAX_FRC = 12
) (
  input  logic          i_clk,
  input  logic          i_rst,
  deg2decimal_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_INT,
    S_FRC,
    S_END
  } state_t;

  localparam logic [3:0] MAX_FRC_W = 4'(MAX_FRC);
  localparam logic [3:0] INT_LAST  = 4'd8;   // 9 bits of integer part

  state_t      state;
  state_t      next_state;

  logic [13:0] deg_q;       // latched angle code
  logic [3:0]  frc_q;       // latched, clamped fractional digit count
  logic [3:0]  cnt;         // cycle counter inside INT / FRC
  logic [8:0]  int_sr;      // integer part, shifted out MSB first
  logic [10:0] frac_q;      // remaining binary fraction (x / 2048)
  logic [63:0] acc;         // BCD accumulator
  logic [63:0] decimal_q;   // published result

  logic [3:0]  frc_clamp;
  logic [19:0] prod;
  logic [11:0] bcd_adj;
  logic [14:0] frc_prod;
  logic [63:0] acc_nxt;
  logic        busy;
  logic        finished;

  // -------------------------------------------------------------------------
  // Datapath arithmetic
  // -------------------------------------------------------------------------

  assign frc_clamp = (bus.i_frccnt > MAX_FRC_W) ? MAX_FRC_W : bus.i_frccnt;

  // code * 45 as a shift-add: 32 + 8 + 4 + 1. Max 16383*45 = 737235 < 2^20.
  assign prod = ({6'b0, deg_q} << 5) + ({6'b0, deg_q} << 3)
              + ({6'b0, deg_q} << 2) +  {6'b0, deg_q};

  // Double-dabble correction: any digit >= 5 would carry out of its nibble
  // after the shift, so pre-add 3.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    bcd_adj = acc[11:0];
    for (int d = 0; d < 3; d++) begin
      if (acc[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // Fraction times ten; the bits above the binary point are the next decimal
  // digit, the bits below are the new remaining fraction. 2047*10 < 2^15.
  assign frc_prod = ({4'b0, frac_q} << 3) + ({4'b0, frac_q} << 1);

  always_comb begin
    acc_nxt = acc;
    unique case (state)
      S_MUL:   acc_nxt = '0;
      S_INT:   acc_nxt = {52'b0, bcd_adj[10:0], int_sr[8]};
      S_FRC:   acc_nxt = {acc[59:0], frc_prod[14:11]};
      default: acc_nxt = acc;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: next state and status outputs
  // -------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    finished   = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.i_start) next_state = S_MUL;
      end
      S_MUL: next_state = S_INT;
      S_INT: begin
        if (cnt == INT_LAST) begin
          next_state = (frc_q == 4'd0) ? S_END : S_FRC;
        end
      end
      S_FRC: begin
        // frc_q >= 1 whenever FRC is entered
        if (cnt == frc_q - 4'd1) next_state = S_END;
      end
      S_END: begin
        finished   = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: every datapath register is cleared by reset so an aborted
    // conversion leaves no stale digits behind.
    if (!i_rst) begin
      deg_q     <= '0;
      frc_q     <= '0;
      cnt       <= '0;
      int_sr    <= '0;
      frac_q    <= '0;
      acc       <= '0;
      decimal_q <= '0;
    end else begin
      // Counter restarts on every state change and runs inside INT / FRC.
      if (state != next_state) begin
        cnt <= '0;
      end else if (state == S_INT || state == S_FRC) begin
        cnt <= cnt + 4'd1;
      end

      unique case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            deg_q <= bus.i_deg;
            frc_q <= frc_clamp;
          end
        end
        S_MUL: begin
          int_sr <= prod[19:11];
          frac_q <= prod[10:0];
          acc    <= acc_nxt;
        end
        S_INT: begin
          int_sr <= {int_sr[7:0], 1'b0};
          acc    <= acc_nxt;
        end
        S_FRC: begin
          frac_q <= frc_prod[10:0];
          acc    <= acc_nxt;
        end
        default: ;
      endcase

      // Publish on entry to END using the value the accumulator is about to
      // take, so the output never shows partial results.
      if (next_state == S_END && state != S_END) begin
        decimal_q <= acc_nxt;
      end
    end
  end

  assign bus.o_decimal  = decimal_q;
  assign bus.o_busy     = busy;
  assign bus.o_finished = finished;

endmodule
